vector_issue_sequencer: RTL

Sequences one vector instruction through the vector register file and datapath, one register of the LMUL group per cycle. It sits between the scalar pipeline and the vector datapath. It latches `vl`/`vsew`/`vlmul` and the register bases on `start_i`, walks the group to generate vs1/vs2/vd read addresses, then issues the delayed write address and per-byte write enables, honouring `vl` tail and v0 protection. It drives the core stall (`hold_o`) and signals completion (`done_o`).

---
 rtl/RS5_pkg.sv | 39 +++
 rtl/vector_issue_sequencer_if.sv | 44 ++++
 rtl/vector_byte_enable_gen.sv | 33 +++
 rtl/vector_issue_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// RS5 shared vector types.
// Adds the issue-sequencer state and the LMUL group-size helper.
package RS5_pkg;

  typedef enum logic [2:0] {
    EW8  = 3'd0,
    EW16 = 3'd1,
    EW32 = 3'd2,
    EW64 = 3'd3
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } vseq_state_e;

  // Fractional groups still occupy one whole register.
  function automatic logic [3:0] vseq_nregs(input vlmul_e m);
    case (m)
      LMUL_2:  vseq_nregs = 4'd2;
      LMUL_4:  vseq_nregs = 4'd4;
      LMUL_8:  vseq_nregs = 4'd8;
      default: vseq_nregs = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/vector_issue_sequencer_if.sv
// Scalar-pipeline / datapath side of the vector issue sequencer.
// master drives requests and consumes addresses; slave is the sequencer.
interface vector_issue_sequencer_if #(
  parameter int VLEN = 64
);
  localparam int VLENB = VLEN / 8;

  logic                    start_i;
  logic [$clog2(VLEN):0]   vl_i;
  logic [2:0]              vsew_i;
  logic [2:0]              vlmul_i;
  logic [4:0]              vs1_base_i;
  logic [4:0]              vs2_base_i;
  logic [4:0]              vd_base_i;
  logic                    vm_i;
  logic [VLEN-1:0]         v0_i;
  logic [4:0]              vs1_addr_o;
  logic [4:0]              vs2_addr_o;
  logic [4:0]              vd_rd_addr_o;
  logic [4:0]              wr_addr_o;
  logic [VLENB-1:0]        wr_be_o;
  logic                    hold_o;
  logic                    done_o;
  logic                    illegal_o;

  modport master (
    output start_i, vl_i, vsew_i, vlmul_i,
    output vs1_base_i, vs2_base_i, vd_base_i,
    output vm_i, v0_i,
    input  vs1_addr_o, vs2_addr_o, vd_rd_addr_o,
    input  wr_addr_o, wr_be_o,
    input  hold_o, done_o, illegal_o
  );

  modport slave (
    input  start_i, vl_i, vsew_i, vlmul_i,
    input  vs1_base_i, vs2_base_i, vd_base_i,
    input  vm_i, v0_i,
    output vs1_addr_o, vs2_addr_o, vd_rd_addr_o,
    output wr_addr_o, wr_be_o,
    output hold_o, done_o, illegal_o
  );

endinterface

// File: rtl/vector_byte_enable_gen.sv
// Per-byte write enables for one register of an LMUL group.
// Element index e = r*(VLENB>>vsew) + (b>>vsew); tail and mask gating.
module vector_byte_enable_gen
  import RS5_pkg::*;
#(
  parameter int VLEN = 64
) (
  input  logic [2:0]              r,
  input  logic [$clog2(VLEN):0]   vl,
  input  vew_e                    vsew,
  input  logic [VLEN-1:0]         mask,
  input  logic                    vm,
  output logic [VLEN/8-1:0]       be
);

  localparam int VLENB = VLEN / 8;
  localparam int EW    = $clog2(VLEN);
  localparam int LB    = $clog2(VLENB);

  logic [EW-1:0] rbase;
  logic [EW-1:0] e;

  always_comb begin
    be    = '0;
    e     = '0;
    rbase = EW'(r) << LB;
    for (int b = 0; b < VLENB; b++) begin
      e     = (rbase >> vsew) + (EW'(b) >> vsew);
      be[b] = ({1'b0, e} < vl) && (vm || mask[e]);
    end
  end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Walks one vector op through its LMUL group, one register per cycle.
// Build with VSEQ_MASK_EN to honour vm/v0 masking on writes.
module vector_issue_sequencer
  import RS5_pkg::*;
#(
  parameter int VLEN = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vector_issue_sequencer_if.slave bus
);

  localparam int VLENB = VLEN / 8;
  localparam int VLW   = $clog2(VLEN) + 1;

  vseq_state_e      state_q;
  vseq_state_e      state_d;
  logic [2:0]       cnt_q;
  logic [3:0]       nregs_q;
  logic [VLW-1:0]   vl_q;
  vew_e             vsew_q;
  logic [4:0]       vs1_q;
  logic [4:0]       vs2_q;
  logic [4:0]       vd_q;
  logic             illegal_q;
  logic             vm_q;
  logic [VLEN-1:0]  v0_q;
  logic             wr_valid_q;
  logic [2:0]       wr_r_q;
  logic [4:0]       wr_addr_q;
  logic [VLENB-1:0] be;
  logic             cfg_illegal;
  logic             capture;
  logic             last;

  assign cfg_illegal = (bus.vsew_i > 3'd2) ||
                       (bus.vlmul_i == 3'd4);
  assign capture = (state_q == IDLE) && bus.start_i;
  assign last    = ({1'b0, cnt_q} == nregs_q - 4'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (cfg_illegal || bus.vl_i == '0) state_d = DRAIN;
          else                               state_d = EXEC;
        end
      end
      EXEC:    if (last) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vl_q      <= '0;
      vsew_q    <= EW8;
      nregs_q   <= 4'd1;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (capture) begin
      vl_q      <= bus.vl_i;
      vsew_q    <= vew_e'(bus.vsew_i);
      nregs_q   <= vseq_nregs(vlmul_e'(bus.vlmul_i));
      vs1_q     <= bus.vs1_base_i;
      vs2_q     <= bus.vs2_base_i;
      vd_q      <= bus.vd_base_i;
      illegal_q <= cfg_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt_q <= '0;
    else if (capture)         cnt_q <= '0;
    else if (state_q == EXEC) cnt_q <= cnt_q + 3'd1;
  end

`ifdef VSEQ_MASK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vm_q <= 1'b1;
      v0_q <= '0;
    end else if (capture) begin
      vm_q <= bus.vm_i;
      v0_q <= bus.v0_i;
    end
  end
`else
  logic unused_mask;
  assign unused_mask = bus.vm_i ^ (^bus.v0_i);
  assign vm_q = 1'b1;
  assign v0_q = '1;
`endif

  // Write stage trails the read by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_valid_q <= 1'b0;
      wr_r_q     <= '0;
      wr_addr_q  <= '0;
    end else begin
      wr_valid_q <= (state_q == EXEC);
      if (state_q == EXEC) begin
        wr_r_q    <= cnt_q;
        wr_addr_q <= vd_q + {2'b00, cnt_q};
      end
    end
  end

  vector_byte_enable_gen #(
    .VLEN (VLEN)
  ) u_be (
    .r    (wr_r_q),
    .vl   (vl_q),
    .vsew (vsew_q),
    .mask (v0_q),
    .vm   (vm_q),
    .be   (be)
  );

  assign bus.vs1_addr_o   = vs1_q + {2'b00, cnt_q};
  assign bus.vs2_addr_o   = vs2_q + {2'b00, cnt_q};
  assign bus.vd_rd_addr_o = vd_q + {2'b00, cnt_q};
  assign bus.wr_addr_o    = wr_addr_q;
  // v0 is never overwritten by a group write.
  assign bus.wr_be_o      = (wr_valid_q && wr_addr_q != 5'd0) ? be : '0;
  assign bus.hold_o       = (state_d != IDLE);
  assign bus.done_o       = (state_q == DRAIN);
  assign bus.illegal_o    = (state_q == DRAIN) && illegal_q;

endmodule
